// File: rtl/rtr_lookahead_route_class_pkg.sv
// Shared constants and helpers for the lookahead route generator.
// Port direction encoding, dimension-order selection, width helpers.
package rtr_lookahead_route_class_pkg;

   localparam int DIR_MINUS   = 0;
   localparam int DIR_PLUS    = 1;
   localparam int NBR_PER_DIM = 2;

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } lar_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int min_w1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   // Even message classes walk dimensions ascending, odd ones descending.
   function automatic int dim_sel(input int step, input int mc, input int nd);
      return ((mc % 2) == 0) ? step : (nd - 1 - step);
   endfunction

endpackage

// File: rtl/rtr_lookahead_route_class_dor_port_select.sv
// Dimension-order port select for a given router and destination.
// Reports whether the chosen network port turns out of the current dimension.
module rtr_dor_port_select
   import rtr_lookahead_route_class_pkg::*;
#(
   parameter int num_dimensions       = 2,
   parameter int num_routers_per_dim  = 4,
   parameter int num_nodes_per_router = 1,
   localparam int DAW = clog2(num_routers_per_dim),
   localparam int RAW = num_dimensions * DAW,
   localparam int NAW = min_w1(clog2(num_nodes_per_router)),
   localparam int NP  = NBR_PER_DIM * num_dimensions + num_nodes_per_router
) (
   input  logic [RAW-1:0]            cur_addr_i,
   input  logic [RAW-1:0]            dest_addr_i,
   input  logic [NAW-1:0]            dest_node_i,
   input  logic                      mc_odd_i,
   input  logic [num_dimensions-1:0] cur_dim_oh_i,
   output logic [NP-1:0]             port_o,
   output logic                      turn_o
);

   logic           found;
   logic [DAW-1:0] c;
   logic [DAW-1:0] t;
   int             d;

   // First differing dimension in class order picks the port; else eject.
   always_comb begin
      port_o = '0;
      turn_o = 1'b0;
      found  = 1'b0;
      c      = '0;
      t      = '0;
      d      = 0;
      for (int s = 0; s < num_dimensions; s++) begin
         d = dim_sel(s, int'(mc_odd_i), num_dimensions);
         c = cur_addr_i[(num_dimensions-1-d)*DAW +: DAW];
         t = dest_addr_i[(num_dimensions-1-d)*DAW +: DAW];
         if (!found && (c != t)) begin
            found = 1'b1;
            if (t > c) port_o[2*d+DIR_PLUS] = 1'b1;
            else port_o[2*d+DIR_MINUS] = 1'b1;
            turn_o = !cur_dim_oh_i[d];
         end
      end
      if (!found) begin
         for (int n = 0; n < num_nodes_per_router; n++) begin
            if (dest_node_i == NAW'(n))
               port_o[NBR_PER_DIM*num_dimensions+n] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rtr_lookahead_route_class.sv
// Per-VC lookahead route generator for the class-ordered phased-DOR mesh.
// Computes next-router output port and resource class, held per packet.
module rtr_lookahead_route_class
   import rtr_lookahead_route_class_pkg::*;
#(
   parameter int num_message_classes  = 2,
   parameter int num_resource_classes = 2,
   parameter int num_vcs_per_class    = 1,
   parameter int num_dimensions       = 2,
   parameter int num_routers_per_dim  = 4,
   parameter int num_nodes_per_router = 1,
   parameter int vc_id                = 0,
   localparam int DAW = clog2(num_routers_per_dim),
   localparam int RAW = num_dimensions * DAW,
   localparam int NAW = min_w1(clog2(num_nodes_per_router)),
   localparam int NP  = NBR_PER_DIM * num_dimensions + num_nodes_per_router,
   localparam int NRC = num_resource_classes
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flit_valid_in,
   input  logic           flit_head_in,
   input  logic           flit_tail_in,
   input  logic [NP-1:0]  route_op_in,
   input  logic [RAW+NAW-1:0] dest_addr_in,
   input  logic [RAW-1:0] router_address,
   output logic           lar_valid_out,
   output logic [NP-1:0]  lar_op_out,
   output logic [NRC-1:0] lar_orc_out,
   output logic           pkt_active_out,
   output logic [1:0]     errors
);

   localparam int NNP    = NBR_PER_DIM * num_dimensions;
   localparam int MC     = (vc_id / (NRC * num_vcs_per_class))
                           % num_message_classes;
   localparam int RC     = (vc_id / num_vcs_per_class) % NRC;
   localparam int RC_NXT = (RC + 1 < NRC) ? RC + 1 : NRC - 1;
   localparam logic [NRC-1:0] RC_OH  = NRC'(1 << RC);
   localparam logic [NRC-1:0] RC_NOH = NRC'(1 << RC_NXT);
   localparam logic MC_ODD = (MC % 2) == 1;

   lar_state_e state_q, state_d;
   logic           valid_q, valid_d;
   logic [NP-1:0]  op_q, op_d;
   logic [NRC-1:0] orc_q, orc_d;
   logic [1:0]     err_q, err_d;
   logic           pkt_q, pkt_d;

   logic [RAW-1:0]            next_addr;
   logic [DAW-1:0]            coord;
   logic [num_dimensions-1:0] cur_dim_oh;
   logic                      step_err;
   logic                      onehot;
   logic                      net_hop;
   logic                      node_hop;
   logic                      route_err;
   logic [NP-1:0]             dor_port;
   logic                      dor_turn;
   logic [NP-1:0]             hd_op;
   logic [NRC-1:0]            hd_orc;

   assign onehot   = (route_op_in != '0) &&
                     ((route_op_in & (route_op_in - NP'(1))) == '0);
   assign net_hop  = |route_op_in[NNP-1:0];
   assign node_hop = |route_op_in[NP-1:NNP];

   // Step this router's coordinates along the selected hop.
   always_comb begin
      next_addr  = router_address;
      step_err   = 1'b0;
      cur_dim_oh = '0;
      coord      = '0;
      for (int d = 0; d < num_dimensions; d++) begin
         coord = router_address[(num_dimensions-1-d)*DAW +: DAW];
         if (route_op_in[2*d+DIR_MINUS]) begin
            cur_dim_oh[d] = 1'b1;
            if (coord == '0) step_err = 1'b1;
            next_addr[(num_dimensions-1-d)*DAW +: DAW] = coord - DAW'(1);
         end
         if (route_op_in[2*d+DIR_PLUS]) begin
            cur_dim_oh[d] = 1'b1;
            if (coord == DAW'(num_routers_per_dim - 1)) step_err = 1'b1;
            next_addr[(num_dimensions-1-d)*DAW +: DAW] = coord + DAW'(1);
         end
      end
   end

   rtr_dor_port_select #(
      .num_dimensions      (num_dimensions),
      .num_routers_per_dim (num_routers_per_dim),
      .num_nodes_per_router(num_nodes_per_router)
   ) u_dor (
      .cur_addr_i  (next_addr),
      .dest_addr_i (dest_addr_in[NAW +: RAW]),
      .dest_node_i (dest_addr_in[NAW-1:0]),
      .mc_odd_i    (MC_ODD),
      .cur_dim_oh_i(cur_dim_oh),
      .port_o      (dor_port),
      .turn_o      (dor_turn)
   );

   assign route_err = !onehot ||
                      (net_hop && (step_err || (dor_port == '0)));

   // Head route result; ejection here or a bad route yields no port.
   always_comb begin
      hd_op  = '0;
      hd_orc = RC_OH;
      if (route_err || node_hop) begin
         hd_op  = '0;
         hd_orc = RC_OH;
      end else begin
         hd_op  = dor_port;
         hd_orc = dor_turn ? RC_NOH : RC_OH;
      end
   end

   // Packet FSM and output next-state.
   always_comb begin
      state_d = state_q;
      valid_d = flit_valid_in;
      op_d    = op_q;
      orc_d   = orc_q;
      err_d   = '0;
      pkt_d   = (state_q == ST_ACTIVE);
      if (flit_valid_in) begin
         if (flit_head_in) begin
            op_d    = hd_op;
            orc_d   = hd_orc;
            err_d   = {route_err, state_q == ST_ACTIVE};
            state_d = flit_tail_in ? ST_IDLE : ST_ACTIVE;
         end else begin
            unique case (state_q)
               ST_ACTIVE: begin
                  if (flit_tail_in) state_d = ST_IDLE;
               end
               ST_IDLE: begin
                  op_d     = '0;
                  orc_d    = '0;
                  err_d[0] = 1'b1;
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         op_q    <= '0;
         orc_q   <= '0;
         err_q   <= '0;
         pkt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         op_q    <= op_d;
         orc_q   <= orc_d;
         err_q   <= err_d;
         pkt_q   <= pkt_d;
      end
   end

   assign lar_valid_out  = valid_q;
   assign lar_op_out     = op_q;
   assign lar_orc_out    = orc_q;
   assign pkt_active_out = pkt_q;
   assign errors         = err_q;

endmodule
